da_addr_gen: RTL and testbench

//  Upstream feeder for the distributed-arithmetic FIR core (da). Holds a 64-tap sample delay line.
//  Per accepted sample, serialises the taps bit-slice by bit-slice, LSB first, into the eight
//  8-bit ROM addresses A7..A0. The DA core consumes one address word per clk.

---
 rtl/da_addr_gen.sv | 168 ++++++++++++++++
 tb/tb_da_addr_gen.sv | 234 +++++++++++++++++++++++
 2 files changed

// File: rtl/da_addr_gen.sv
// rtl/da_addr_gen.sv - 64-tap delay line and bit-slice ROM address serialiser for the DA FIR core
//
// Holds the 64 most recent samples (tap[0] newest). For every accepted sample it emits DW
// address words, one bit-slice per word, LSB first. Bit j of A_k is bit b of tap[8k+j].
//
// Ports:
//   clk          in   rising-edge system clock
//   resetn       in   asynchronous active-low reset
//   flush        in   (DA_FLUSH_EN only) zero the delay line while idle
//   sample_in    in   [DW-1:0] new sample x[n], two's complement
//   sample_valid in   sample_in valid
//   sample_ready out  block is idle and can take a sample
//   A7..A0       out  [7:0] ROM address for each 8-tap group
//   addr_valid   out  A7..A0 carry a valid bit-slice
//   addr_ready   in   DA core takes the slice this cycle
//   addr_first   out  slice is bit 0 (DA clears its accumulator)
//   addr_last    out  slice is bit DW-1, the sign slice (DA subtracts)
//
// Optional feature: define DA_FLUSH_EN to add the flush port.

module da_addr_gen #(
  parameter int DW     = 16,
  parameter int BCNT_W = 4
) (
  input  logic          clk,
  input  logic          resetn,
`ifdef DA_FLUSH_EN
  input  logic          flush,
`endif
  input  logic [DW-1:0] sample_in,
  input  logic          sample_valid,
  output logic          sample_ready,
  output logic [7:0]    A7,
  output logic [7:0]    A6,
  output logic [7:0]    A5,
  output logic [7:0]    A4,
  output logic [7:0]    A3,
  output logic [7:0]    A2,
  output logic [7:0]    A1,
  output logic [7:0]    A0,
  output logic          addr_valid,
  input  logic          addr_ready,
  output logic          addr_first,
  output logic          addr_last
);

  localparam int NTAPS = 64;
  localparam logic [BCNT_W-1:0] BCNT_LAST = BCNT_W'(DW - 1);

  typedef enum logic {IDLE, SER} state_t;

  state_t              state, state_nxt;
  logic [DW-1:0]       taps [0:NTAPS-1];
  logic [NTAPS-1:0]    addr_q;
  logic                first_q, last_q;
  logic [BCNT_W-1:0]   bcnt, bcnt_inc;
  logic                accept, xfer, clear_taps, flush_req;
  logic [NTAPS-1:0]    slice_accept, slice_step;

`ifdef DA_FLUSH_EN
  assign flush_req = flush;
`else
  assign flush_req = 1'b0;
`endif

  assign bcnt_inc = bcnt + BCNT_W'(1);

  // State register
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) state <= IDLE;
    else         state <= state_nxt;
  end

  // Next state and handshake decode
  always_comb begin
    state_nxt    = state;
    accept       = 1'b0;
    xfer         = 1'b0;
    clear_taps   = 1'b0;
    sample_ready = 1'b0;
    addr_valid   = 1'b0;
    case (state)
      IDLE: begin
        // A flush cycle refuses the sample so it is never lost into a cleared line.
        sample_ready = !flush_req;
        if (flush_req) begin
          clear_taps = 1'b1;
        end else if (sample_valid) begin
          accept    = 1'b1;
          state_nxt = SER;
        end
      end
      SER: begin
        addr_valid = 1'b1;
        if (addr_ready) begin
          xfer = 1'b1;
          if (bcnt == BCNT_LAST) state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Slice 0 of the line as it will look after the shift, so the first word
  // is ready the cycle right after acceptance.
  always_comb begin
    slice_accept    = '0;
    slice_accept[0] = sample_in[0];
    for (int i = 1; i < NTAPS; i++) slice_accept[i] = taps[i-1][0];
  end

  // Next slice of the current (frozen) line
  always_comb begin
    slice_step = '0;
    for (int i = 0; i < NTAPS; i++) slice_step[i] = taps[i][bcnt_inc];
  end

  // Delay line: moves only on acceptance (or flush), so it is stable through a frame
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      for (int i = 0; i < NTAPS; i++) taps[i] <= '0;
    end else if (clear_taps) begin
      for (int i = 0; i < NTAPS; i++) taps[i] <= '0;
    end else if (accept) begin
      taps[0] <= sample_in;
      for (int i = 1; i < NTAPS; i++) taps[i] <= taps[i-1];
    end
  end

  // Registered address word, slice counter and frame markers; all hold on stall
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      bcnt    <= '0;
      addr_q  <= '0;
      first_q <= 1'b0;
      last_q  <= 1'b0;
    end else if (accept) begin
      bcnt    <= '0;
      addr_q  <= slice_accept;
      first_q <= 1'b1;
      last_q  <= (BCNT_LAST == '0);
    end else if (xfer) begin
      if (bcnt == BCNT_LAST) begin
        bcnt    <= '0;
        addr_q  <= '0;
        first_q <= 1'b0;
        last_q  <= 1'b0;
      end else begin
        bcnt    <= bcnt_inc;
        addr_q  <= slice_step;
        first_q <= 1'b0;
        last_q  <= (bcnt_inc == BCNT_LAST);
      end
    end
  end

  assign A0         = addr_q[7:0];
  assign A1         = addr_q[15:8];
  assign A2         = addr_q[23:16];
  assign A3         = addr_q[31:24];
  assign A4         = addr_q[39:32];
  assign A5         = addr_q[47:40];
  assign A6         = addr_q[55:48];
  assign A7         = addr_q[63:56];
  assign addr_first = first_q;
  assign addr_last  = last_q;

endmodule

// File: tb/tb_da_addr_gen.sv
// tb/tb_da_addr_gen.sv - self-checking bench for da_addr_gen
module tb_da_addr_gen;

  logic        clk = 1'b0;
  logic        resetn;
  logic [15:0] sample_in;
  logic        sample_valid;
  logic        sample_ready;
  logic [7:0]  A7, A6, A5, A4, A3, A2, A1, A0;
  logic        addr_valid;
  logic        addr_ready;
  logic        addr_first;
  logic        addr_last;
`ifdef DA_FLUSH_EN
  logic        flush;
`endif

  da_addr_gen #(.DW(16), .BCNT_W(4)) dut (
    .clk(clk), .resetn(resetn),
`ifdef DA_FLUSH_EN
    .flush(flush),
`endif
    .sample_in(sample_in), .sample_valid(sample_valid), .sample_ready(sample_ready),
    .A7(A7), .A6(A6), .A5(A5), .A4(A4), .A3(A3), .A2(A2), .A1(A1), .A0(A0),
    .addr_valid(addr_valid), .addr_ready(addr_ready),
    .addr_first(addr_first), .addr_last(addr_last)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [63:0] a;
    logic        first;
    logic        last;
  } slice_t;

  int          checks = 0;
  int          errors = 0;
  logic [15:0] m [0:63];
  slice_t      sb [$];
  int          cyc;

  function automatic logic [63:0] dut_addr();
    return {A7, A6, A5, A4, A3, A2, A1, A0};
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic model_clear();
    for (int i = 0; i < 64; i++) m[i] = '0;
    sb.delete();
  endtask

  // Shift the reference line and queue the 16 slices the DUT must produce
  task automatic model_push(input logic [15:0] s);
    slice_t e;
    for (int i = 63; i > 0; i--) m[i] = m[i-1];
    m[0] = s;
    for (int b = 0; b < 16; b++) begin
      e.a = '0;
      for (int i = 0; i < 64; i++) e.a[i] = m[i][b];
      e.first = (b == 0);
      e.last  = (b == 15);
      sb.push_back(e);
    end
  endtask

  task automatic push(input string tag, input logic [15:0] s);
    chk({tag, ".ready"}, 64'(sample_ready), 64'd1);
    sample_in    = s;
    sample_valid = 1'b1;
    model_push(s);
    step();
    sample_valid = 1'b0;
    sample_in    = ~s;
  endtask

  // Consume queued slices; optional stall at slice stall_at and junk samples mid-frame
  task automatic drain(input string tag, input int stall_at, input int stall_len,
                       input bit poke, output int cycles);
    slice_t e;
    int     xfers;
    int     stalled;
    xfers   = 0;
    stalled = 0;
    cycles  = 0;
    while (sb.size() > 0 && cycles < 200) begin
      e = sb[0];
      chk({tag, ".valid"}, 64'(addr_valid), 64'd1);
      chk({tag, ".addr"}, dut_addr(), e.a);
      chk({tag, ".first_last"}, 64'({addr_first, addr_last}), 64'({e.first, e.last}));
      chk({tag, ".busy"}, 64'(sample_ready), 64'd0);
      if (xfers == stall_at && stalled < stall_len) begin
        addr_ready = 1'b0;
        stalled++;
      end else begin
        addr_ready = 1'b1;
      end
      sample_valid = poke && xfers >= 2 && xfers <= 4;
      sample_in    = 16'hA5C3;
      if (addr_ready) begin
        void'(sb.pop_front());
        xfers++;
      end
      cycles++;
      step();
    end
    sample_valid = 1'b0;
    addr_ready   = 1'b1;
    chk({tag, ".left"}, 64'(sb.size()), 64'd0);
    chk({tag, ".idle_ready"}, 64'(sample_ready), 64'd1);
    chk({tag, ".idle_valid"}, 64'(addr_valid), 64'd0);
  endtask

  task automatic do_reset();
    resetn = 1'b0;
    model_clear();
    step();
    step();
    resetn = 1'b1;
  endtask

  initial begin
    resetn       = 1'b0;
    sample_in    = '0;
    sample_valid = 1'b0;
    addr_ready   = 1'b1;
`ifdef DA_FLUSH_EN
    flush        = 1'b0;
`endif
    model_clear();
    step();
    step();

    // 1 Reset state, then idle with no samples
    chk("rst.addr", dut_addr(), 64'd0);
    chk("rst.valid", 64'(addr_valid), 64'd0);
    chk("rst.ready", 64'(sample_ready), 64'd1);
    chk("rst.fl", 64'({addr_first, addr_last}), 64'd0);
    resetn = 1'b1;
    repeat (3) step();
    chk("idle.valid", 64'(addr_valid), 64'd0);
    chk("idle.ready", 64'(sample_ready), 64'd1);

    // 2 Impulse, then ageing by one tap (with ignored samples mid-frame)
    push("imp", 16'h0001);
    chk("imp.s0", dut_addr(), 64'h01);
    chk("imp.first", 64'(addr_first), 64'd1);
    drain("imp", -1, 0, 1'b0, cyc);
    chk("imp.cycles", 64'(cyc), 64'd16);
    push("age", 16'h0000);
    chk("age.s0", dut_addr(), 64'h02);
    drain("age", -1, 0, 1'b1, cyc);
    push("after_poke", 16'h0000);
    chk("after_poke.s0", dut_addr(), 64'h04);
    drain("after_poke", -1, 0, 1'b0, cyc);

    // 3 Sign slice from reset
    do_reset();
    push("sign", 16'h8000);
    chk("sign.s0", dut_addr(), 64'h0);
    drain("sign", -1, 0, 1'b0, cyc);

    // 4 Backpressure during slice 5
    push("bp", 16'h5A3C);
    drain("bp", 5, 3, 1'b0, cyc);
    chk("bp.cycles", 64'(cyc), 64'd19);

    // 5 Fill with all ones, then age in a zero
    for (int k = 0; k < 64; k++) begin
      push("fill", 16'hFFFF);
      drain("fill", -1, 0, 1'b0, cyc);
    end
    push("full", 16'hFFFF);
    chk("full.s0", dut_addr(), 64'hFFFF_FFFF_FFFF_FFFF);
    drain("full", -1, 0, 1'b0, cyc);
    push("zero_in", 16'h0000);
    chk("zero_in.s0", dut_addr(), 64'hFFFF_FFFF_FFFF_FFFE);
    drain("zero_in", -1, 0, 1'b0, cyc);

    // 6 Mid-frame reset during slice 7
    push("mid", 16'h0001);
    repeat (7) begin
      void'(sb.pop_front());
      step();
    end
    chk("mid.valid_pre", 64'(addr_valid), 64'd1);
    #2;
    resetn = 1'b0;
    #1;
    chk("mid.valid_async", 64'(addr_valid), 64'd0);
    chk("mid.addr_async", dut_addr(), 64'd0);
    chk("mid.ready_async", 64'(sample_ready), 64'd1);
    model_clear();
    step();
    resetn = 1'b1;
    push("post", 16'h0001);
    chk("post.s0", dut_addr(), 64'h01);
    drain("post", -1, 0, 1'b0, cyc);

`ifdef DA_FLUSH_EN
    push("pre_flush", 16'hFFFF);
    drain("pre_flush", -1, 0, 1'b0, cyc);
    flush        = 1'b1;
    sample_valid = 1'b1;
    sample_in    = 16'h1111;
    #1;
    chk("flush.ready", 64'(sample_ready), 64'd0);
    step();
    flush        = 1'b0;
    sample_valid = 1'b0;
    chk("flush.idle", 64'(addr_valid), 64'd0);
    model_clear();
    push("post_flush", 16'h0000);
    chk("post_flush.s0", dut_addr(), 64'h0);
    drain("post_flush", -1, 0, 1'b0, cyc);
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
